// File: rtl/pwm_capture.sv
// PWM receiver: recovers duty (high cycles) and period-1 from a PWM input.
// Constant-level inputs are reported as stuck after a period timeout.
module pwm_capture #(
  parameter int WIDTH       = 9,
  parameter int COUNT_WIDTH = 9,
  parameter int TIMEOUT     = 512
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   pwm_in,
  output logic [WIDTH-1:0]       duty_cycle,
  output logic [COUNT_WIDTH-1:0] count_value,
  output logic                   valid,
  output logic                   stuck,
  output logic                   level
);

  localparam int PW = COUNT_WIDTH + 1;
  localparam logic [PW-1:0] TMO = PW'(TIMEOUT);

  typedef enum logic {IDLE, MEAS} state_e;

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic rise, tmo;

  logic [PW-1:0]          period_q, period_d;
  logic [WIDTH-1:0]       high_q, high_d;
  logic [WIDTH-1:0]       duty_q, duty_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   stuck_q, stuck_d;
  logic                   level_q, level_d;

  assign rise = s2_q & ~s3_q;
  assign tmo  = (period_q == TMO);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    level_d  = level_q;
    if (!enable) begin
      state_d  = IDLE;
      period_d = '0;
      high_d   = '0;
    end else if (rise) begin
      // first rise after IDLE only arms the measurement
      if (state_q == MEAS) begin
        duty_d  = high_q;
        cnt_d   = COUNT_WIDTH'(period_q - PW'(1));
        stuck_d = 1'b0;
        valid_d = 1'b1;
      end
      state_d  = MEAS;
      period_d = PW'(1);
      high_d   = WIDTH'(1);
    end else if (tmo) begin
      duty_d   = s2_q ? '1 : '0;
      cnt_d    = '1;
      stuck_d  = 1'b1;
      level_d  = s2_q;
      valid_d  = 1'b1;
      period_d = '0;
      high_d   = '0;
      state_d  = IDLE;
    end else begin
      period_d = period_q + PW'(1);
      if (state_q == MEAS && s2_q && high_q != '1)
        high_d = high_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= pwm_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      level_q  <= level_d;
    end
  end

  assign duty_cycle  = duty_q;
  assign count_value = cnt_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign level       = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: loopback, extremes, timeouts,
// period change, reset and enable aborts.
module tb_pwm_capture;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       pwm_in;
  logic [8:0] duty_cycle;
  logic [8:0] count_value;
  logic       valid;
  logic       stuck;
  logic       level;

  typedef struct {
    int         cyc;
    logic [8:0] duty;
    logic [8:0] cnt;
    logic       stuck;
    logic       level;
  } rep_t;

  rep_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  pwm_capture #(
    .WIDTH(9),
    .COUNT_WIDTH(9),
    .TIMEOUT(512)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .pwm_in(pwm_in),
    .duty_cycle(duty_cycle),
    .count_value(count_value),
    .valid(valid),
    .stuck(stuck),
    .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1)
      q.push_back('{cyc, duty_cycle, count_value, stuck, level});
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic seg(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  task automatic chk_rep(input string tag, input int idx,
                         input int d, input int c,
                         input int s, input int l);
    if (idx < q.size()) begin
      check({tag, ".duty"},  32'(q[idx].duty),  32'(d));
      check({tag, ".cnt"},   32'(q[idx].cnt),   32'(c));
      check({tag, ".stuck"}, 32'(q[idx].stuck), 32'(s));
      check({tag, ".level"}, 32'(q[idx].level), 32'(l));
    end else begin
      check({tag, ".present"}, 32'(q.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_gap(input string tag, input int a, input int b,
                         input int gap);
    if (b < q.size())
      check(tag, 32'(q[b].cyc - q[a].cyc), 32'(gap));
    else
      check({tag, ".present"}, 32'(q.size()), 32'(b + 1));
  endtask

  task automatic chk_outs(input string tag, input int d, input int c,
                          input int s, input int l, input int v);
    check({tag, ".duty"},  32'(duty_cycle),  32'(d));
    check({tag, ".cnt"},   32'(count_value), 32'(c));
    check({tag, ".stuck"}, 32'(stuck),       32'(s));
    check({tag, ".level"}, 32'(level),       32'(l));
    check({tag, ".valid"}, 32'(valid),       32'(v));
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(1'b0, 4);

    // nominal 25/100: first rise silent, then one report per period
    q.delete();
    seg(25, 100, 5);
    check("nom.n", 32'(q.size()), 32'd4);
    chk_rep("nom.first", 0, 25, 99, 0, 0);
    chk_rep("nom.last", 3, 25, 99, 0, 0);
    chk_gap("nom.gap", 0, 3, 300);

    // period change: one transitional report, then the new shape
    q.delete();
    seg(60, 200, 3);
    check("chg.n", 32'(q.size()), 32'd3);
    chk_rep("chg.trans", 0, 25, 99, 0, 0);
    chk_rep("chg.new", 2, 60, 199, 0, 0);
    chk_gap("chg.gap", 1, 2, 200);

    // shortest period; trailing low lets the last report land
    q.delete();
    seg(1, 2, 4);
    drive(1'b0, 3);
    check("p2.n", 32'(q.size()), 32'd4);
    chk_rep("p2.trans", 0, 60, 199, 0, 0);
    chk_rep("p2.last", 3, 1, 1, 0, 0);
    chk_gap("p2.gap", 2, 3, 2);

    // longest legal period: rise coincides with period_cnt==TIMEOUT
    q.delete();
    seg(511, 512, 3);
    check("p512.n", 32'(q.size()), 32'd3);
    chk_rep("p512.trans", 0, 1, 4, 0, 0);
    chk_rep("p512.mid", 1, 511, 511, 0, 0);
    chk_rep("p512.last", 2, 511, 511, 0, 0);

    // constant high straight after: one normal report, then timeouts
    q.delete();
    drive(1'b1, 1600);
    check("hi.n", 32'(q.size()), 32'd4);
    chk_rep("hi.norm", 0, 511, 511, 0, 0);
    chk_rep("hi.tmo1", 1, 511, 511, 1, 1);
    chk_rep("hi.tmo3", 3, 511, 511, 1, 1);
    chk_gap("hi.gap1", 0, 1, 512);
    chk_gap("hi.gap2", 2, 3, 513);

    q.delete();
    drive(1'b0, 1100);
    check("lo.n", 32'(q.size()), 32'd2);
    chk_rep("lo.tmo1", 0, 0, 511, 1, 0);
    chk_rep("lo.tmo2", 1, 0, 511, 1, 0);
    chk_gap("lo.gap", 0, 1, 513);

    // reset in mid-period discards everything
    q.delete();
    seg(25, 100, 2);
    check("rst.pre.n", 32'(q.size()), 32'd1);
    chk_rep("rst.pre", 0, 25, 99, 0, 0);
    drive(1'b1, 25);
    drive(1'b0, 20);
    reset_n = 1'b0;
    @(negedge clk);
    chk_outs("rst.mid", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(1'b0, 55);
    q.delete();
    seg(25, 100, 1);
    check("rst.rise1.n", 32'(q.size()), 32'd0);
    check("rst.rise1.duty", 32'(duty_cycle), 32'd0);
    seg(25, 100, 1);
    check("rst.rise2.n", 32'(q.size()), 32'd1);
    chk_rep("rst.rise2", 0, 25, 99, 0, 0);

    // enable low: outputs hold, no valid, measurement restarts
    drive(1'b1, 25);
    q.delete();
    drive(1'b0, 30);
    enable = 1'b0;
    drive(1'b0, 10);
    check("en.off.n", 32'(q.size()), 32'd0);
    chk_outs("en.hold", 25, 99, 0, 0, 0);
    enable = 1'b1;
    drive(1'b0, 35);
    seg(25, 100, 1);
    check("en.rise1.n", 32'(q.size()), 32'd0);
    seg(40, 100, 1);
    check("en.rise2.n", 32'(q.size()), 32'd1);
    chk_rep("en.rise2", 0, 25, 99, 0, 0);
    drive(1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
